// File: rtl/multi_edge_detect.sv
// multi_edge_detect: per-channel synchronised, debounced edge detector with sticky event/overrun flags
module multi_edge_detect #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   event_flag,
  output logic [CHANNELS-1:0]   overrun
);
  localparam int CW = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
  typedef enum logic [5:0] {
    IDLE_LOW  = 6'b000001,
    QUAL_HIGH = 6'b000010,
    EDGE_HIGH = 6'b000100,
    IDLE_HIGH = 6'b001000,
    QUAL_LOW  = 6'b010000,
    EDGE_LOW  = 6'b100000
  } state_t;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   pulse_q, pulse_d;
    logic                   level_q, level_d;
    logic                   evt_q, evt_d;
    logic                   ovr_q, ovr_d;
    logic                   s;
    assign s = sync_q[SYNC_STAGES-1];
    // next state: synchroniser shift, debounce FSM, and outputs decoded from the state being entered
    always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], in[g]};
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        IDLE_LOW:
          if (s) begin
            if (FILTER_CYCLES == 1) state_d = EDGE_HIGH;
            else state_d = QUAL_HIGH;
            cnt_d = CW'(1);
          end
        QUAL_HIGH:
          if (!s) state_d = IDLE_LOW;
          else if (cnt_q == LAST) state_d = EDGE_HIGH;
          else cnt_d = cnt_q + CW'(1);
        EDGE_HIGH: state_d = IDLE_HIGH;
        IDLE_HIGH:
          if (!s) begin
            if (FILTER_CYCLES == 1) state_d = EDGE_LOW;
            else state_d = QUAL_LOW;
            cnt_d = CW'(1);
          end
        QUAL_LOW:
          if (s) state_d = IDLE_HIGH;
          else if (cnt_q == LAST) state_d = EDGE_LOW;
          else cnt_d = cnt_q + CW'(1);
        EDGE_LOW: state_d = IDLE_LOW;
        default: state_d = IDLE_LOW;
      endcase
      pulse_d = (state_d == EDGE_HIGH && mode[2*g]) || (state_d == EDGE_LOW && mode[2*g+1]);
      level_d = state_d == EDGE_HIGH || state_d == IDLE_HIGH || state_d == QUAL_LOW;
      evt_d   = pulse_q | (evt_q & ~clear[g]);
      ovr_d   = (pulse_q & evt_q & ~clear[g]) | (ovr_q & ~clear[g]);
    end
    // channel state register; clear racing a pulse discards the old flag so no overrun is reported
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q  <= '0;
        state_q <= IDLE_LOW;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
        level_q <= 1'b0;
        evt_q   <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
        level_q <= level_d;
        evt_q   <= evt_d;
        ovr_q   <= ovr_d;
      end
    end
    assign pulse[g]      = pulse_q;
    assign level[g]      = level_q;
    assign event_flag[g] = evt_q;
    assign overrun[g]    = ovr_q;
  end
endmodule
